// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions: memory opcodes, datapath widths and the memory-stage state encoding.
package mem_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  localparam logic [3:0] OP_LW = 4'b1000;
  localparam logic [3:0] OP_SW = 4'b1001;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic [3:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Request/acknowledge sequencer for the data-memory port: owns state, dmem_req,
// mem_stall and the saturating stall counter.
module mem_access_fsm
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dmem_ack,
  output state_t      state,
  output logic        done,
  output logic        dmem_req,
  output logic        mem_stall,
  output logic [15:0] stall_count
);

  state_t state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ACCESS;
      end
      ACCESS: begin
        // ack only counts while a request is outstanding
        if (dmem_ack) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_stall = (state == ACCESS);
  assign dmem_req  = (state == ACCESS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (mem_stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: captures execute results, runs LW/SW transactions to a
// variable-latency data memory, and emits one writeback record per instruction.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [3:0]          ex_opcode,
  input  logic [DATA_W-1:0]   ex_alu_result,
  input  logic [DATA_W-1:0]   ex_store_data,
  input  logic [REG_AW-1:0]   ex_rd,
  input  logic                ex_reg_write,
  input  logic                flush,
  output logic                mem_stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [DATA_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic                dmem_ack,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                wb_valid,
  output logic [REG_AW-1:0]   wb_rd,
  output logic [DATA_W-1:0]   wb_data,
  output logic                wb_reg_write,
  output logic [15:0]         stall_count
);

  localparam logic [DATA_W-1:0] ADDR_MASK = ~DATA_W'(1);

  state_t state;
  logic   accept;
  logic   start;
  logic   done;

  assign accept = (state == IDLE) && ex_valid && !flush;
  assign start  = accept && is_mem_op(ex_opcode);

  mem_access_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dmem_ack    (dmem_ack),
    .state       (state),
    .done        (done),
    .dmem_req    (dmem_req),
    .mem_stall   (mem_stall),
    .stall_count (stall_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_reg_write <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (start) begin
        dmem_addr    <= ex_alu_result & ADDR_MASK;
        dmem_wdata   <= ex_store_data;
        dmem_we      <= (ex_opcode == OP_SW);
        wb_rd        <= ex_rd;
        wb_reg_write <= ex_reg_write;
      end else if (accept) begin
        wb_valid     <= 1'b1;
        wb_data      <= ex_alu_result;
        wb_rd        <= ex_rd;
        wb_reg_write <= ex_reg_write;
      end else if (done) begin
        wb_valid <= 1'b1;
        // stores report their address and never write the register file
        if (dmem_we) begin
          wb_data      <= dmem_addr;
          wb_reg_write <= 1'b0;
        end else begin
          wb_data <= dmem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU passthrough, LW/SW handshakes, flush, reset
// mid-transaction and stall-counter saturation.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_alu_result;
  logic [15:0] ex_store_data;
  logic [3:0]  ex_rd;
  logic        ex_reg_write;
  logic        flush;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_reg_write;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_opcode     (ex_opcode),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .flush         (flush),
    .mem_stall     (mem_stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_reg_write  (wb_reg_write),
    .stall_count   (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [15:0] alu,
                         input logic [15:0] sdata, input logic [3:0] rd, input logic rw);
    ex_valid      = 1'b1;
    ex_opcode     = op;
    ex_alu_result = alu;
    ex_store_data = sdata;
    ex_rd         = rd;
    ex_reg_write  = rw;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_opcode = 4'h0; ex_alu_result = '0; ex_store_data = '0;
    ex_rd = '0; ex_reg_write = 1'b0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    #12;
    check("rst_req",    32'(dmem_req), 32'd0);
    check("rst_stall",  32'(mem_stall), 32'd0);
    check("rst_wbv",    32'(wb_valid), 32'd0);
    check("rst_count",  32'(stall_count), 32'd0);
    check("rst_addr",   32'(dmem_addr), 32'd0);
    rst = 1'b0;

    // ADD passthrough
    present(4'h0, 16'h1234, 16'h0000, 4'd3, 1'b1);
    step();
    check("add_wbv",  32'(wb_valid), 32'd1);
    check("add_data", 32'(wb_data), 32'h1234);
    check("add_rd",   32'(wb_rd), 32'd3);
    check("add_rw",   32'(wb_reg_write), 32'd1);
    check("add_req",  32'(dmem_req), 32'd0);
    ex_valid = 1'b0;
    step();
    check("add_wbv_end", 32'(wb_valid), 32'd0);

    // LW, ack after 3 request cycles; upstream keeps a non-memory op presented
    present(4'b1000, 16'h0041, 16'h0000, 4'd5, 1'b1);
    step();
    check("lw_req",   32'(dmem_req), 32'd1);
    check("lw_addr",  32'(dmem_addr), 32'h0040);
    check("lw_we",    32'(dmem_we), 32'd0);
    check("lw_stall", 32'(mem_stall), 32'd1);
    present(4'h0, 16'hFFFF, 16'h0000, 4'd9, 1'b1);
    step();
    check("lw_hold_req", 32'(dmem_req), 32'd1);
    check("lw_hold_wbv", 32'(wb_valid), 32'd0);
    step();
    check("lw_hold_addr", 32'(dmem_addr), 32'h0040);
    dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
    step();
    ex_valid = 1'b0; dmem_ack = 1'b0;
    check("lw_wbv",   32'(wb_valid), 32'd1);
    check("lw_data",  32'(wb_data), 32'hBEEF);
    check("lw_rd",    32'(wb_rd), 32'd5);
    check("lw_rw",    32'(wb_reg_write), 32'd1);
    check("lw_req_off",   32'(dmem_req), 32'd0);
    check("lw_stall_off", 32'(mem_stall), 32'd0);
    check("lw_count", 32'(stall_count), 32'd3);
    step();
    check("lw_single_wbv", 32'(wb_valid), 32'd0);

    // SW with immediate ack, then XOR accepted one cycle after the ack edge
    present(4'b1001, 16'h0010, 16'h00AA, 4'd7, 1'b1);
    step();
    check("sw_we",    32'(dmem_we), 32'd1);
    check("sw_wdata", 32'(dmem_wdata), 32'h00AA);
    check("sw_addr",  32'(dmem_addr), 32'h0010);
    present(4'b0101, 16'h5A5A, 16'h0000, 4'd2, 1'b1);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("sw_wbv",   32'(wb_valid), 32'd1);
    check("sw_rw",    32'(wb_reg_write), 32'd0);
    check("sw_data",  32'(wb_data), 32'h0010);
    check("sw_count", 32'(stall_count), 32'd4);
    step();
    check("xor_wbv",  32'(wb_valid), 32'd1);
    check("xor_data", 32'(wb_data), 32'h5A5A);
    check("xor_rd",   32'(wb_rd), 32'd2);
    ex_valid = 1'b0;
    step();
    check("xor_wbv_end", 32'(wb_valid), 32'd0);

    // flush discards a presented LW
    present(4'b1000, 16'h0030, 16'h0000, 4'd6, 1'b1);
    flush = 1'b1;
    step();
    check("flush_req", 32'(dmem_req), 32'd0);
    check("flush_wbv", 32'(wb_valid), 32'd0);
    flush = 1'b0;
    // flush during ACCESS does not abort
    present(4'b1000, 16'h0022, 16'h0000, 4'd4, 1'b1);
    step();
    check("fa_addr", 32'(dmem_addr), 32'h0022);
    ex_valid = 1'b0; flush = 1'b1;
    step();
    check("fa_req_held", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 16'h1111;
    step();
    dmem_ack = 1'b0; flush = 1'b0;
    check("fa_wbv",   32'(wb_valid), 32'd1);
    check("fa_data",  32'(wb_data), 32'h1111);
    check("fa_count", 32'(stall_count), 32'd6);

    // reset mid-ACCESS, then a spurious ack
    present(4'b1001, 16'h0101, 16'h00CC, 4'd8, 1'b1);
    step();
    ex_valid = 1'b0;
    check("mr_req_pre", 32'(dmem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mr_req",   32'(dmem_req), 32'd0);
    check("mr_stall", 32'(mem_stall), 32'd0);
    check("mr_we",    32'(dmem_we), 32'd0);
    check("mr_addr",  32'(dmem_addr), 32'd0);
    check("mr_wdata", 32'(dmem_wdata), 32'd0);
    check("mr_wbdata", 32'(wb_data), 32'd0);
    check("mr_count", 32'(stall_count), 32'd0);
    #1 rst = 1'b0;
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("spur_wbv",   32'(wb_valid), 32'd0);
    check("spur_stall", 32'(mem_stall), 32'd0);
    present(4'h0, 16'h0777, 16'h0000, 4'd1, 1'b1);
    step();
    ex_valid = 1'b0;
    check("pr_wbv",  32'(wb_valid), 32'd1);
    check("pr_data", 32'(wb_data), 32'h0777);

    // long stall drives stall_count to saturation
    present(4'b1000, 16'h0200, 16'h0000, 4'd2, 1'b1);
    step();
    ex_valid = 1'b0;
    repeat (65534) step();
    check("sat_fffe", 32'(stall_count), 32'hFFFE);
    repeat (5) step();
    check("sat_ffff", 32'(stall_count), 32'hFFFF);
    check("sat_req",  32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 16'hABCD;
    step();
    dmem_ack = 1'b0;
    check("sat_wbv",   32'(wb_valid), 32'd1);
    check("sat_data",  32'(wb_data), 32'hABCD);
    check("sat_final", 32'(stall_count), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 16-bit pipelined CPU, directly downstream of the ALU/execute stage. It consumes the execute result (the ALU output, which is the effective address for LW/SW), runs a request/acknowledge transaction to a variable-latency data memory for loads and stores, and stalls the upstream pipeline while that transaction is in flight. It delivers exactly one writeback record per accepted instruction.

## Interface
- DATA_W, 16, datapath and address width
- REG_AW, 4, register-file index width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  execute stage presents an instruction
- ex_opcode  in  4  instruction opcode (4'b1000 = LW, 4'b1001 = SW)
- ex_alu_result  in  DATA_W  ALU output: effective address for LW/SW, result otherwise
- ex_store_data  in  DATA_W  SW source register value
- ex_rd  in  REG_AW  destination register
- ex_reg_write  in  1  instruction writes the register file
- flush  in  1  discard the instruction presented this cycle
- mem_stall  out  1  upstream must hold its outputs
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write (SW), 0 = read (LW)
- dmem_addr  out  DATA_W  word-aligned address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  memory completion, sampled only while dmem_req = 1
- dmem_rdata  in  DATA_W  load data, valid in the cycle dmem_ack = 1
- wb_valid  out  1  one-cycle pulse: writeback record valid
- wb_rd  out  REG_AW  writeback register
- wb_data  out  DATA_W  writeback data
- wb_reg_write  out  1  register-file write enable for this record
- stall_count  out  16  saturating count of cycles with mem_stall = 1

## Operation
- FSM states:
  - IDLE: stage can accept an instruction.
  - ACCESS: memory transaction outstanding.
- IDLE, on a clock edge with ex_valid = 1 and flush = 0:
  - Opcode neither LW nor SW: register ex_alu_result, ex_rd and ex_reg_write into the wb outputs, assert wb_valid for the next cycle, and stay in IDLE.
  - LW or SW: register dmem_addr = {ex_alu_result[15:1], 1'b0}, dmem_wdata = ex_store_data, dmem_we = (opcode == SW), wb_rd and wb_reg_write; set dmem_req = 1; go to ACCESS.
- Flush, or ex_valid = 0, in IDLE: nothing is captured and wb_valid = 0.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata hold stable until an edge where dmem_ack = 1.
  - On that edge: dmem_req becomes 0; wb_valid pulses; the stage returns to IDLE.
  - LW: wb_data = dmem_rdata and wb_reg_write is as captured.
  - SW: wb_reg_write is forced to 0 and wb_data = dmem_addr.
- mem_stall = (state == ACCESS). It is combinational from state, not from ex_valid.
- Inputs are ignored while in ACCESS; flush in ACCESS does not abort the transaction.
- dmem_ack sampled in IDLE is ignored.
- stall_count increments on every edge where mem_stall = 1 and saturates at 16'hFFFF.
- Reset, including mid-ACCESS: state = IDLE; dmem_req, dmem_we, wb_valid, wb_reg_write and mem_stall = 0; dmem_addr, dmem_wdata, wb_data, wb_rd and stall_count = 0. These take effect immediately and asynchronously; the outstanding transaction is abandoned.

## Timing
- Non-memory instruction: captured at edge N; wb_valid is high from N to N+1. Throughput is 1 per cycle.
- LW/SW captured at edge N:
  - dmem_req is high from N.
  - The first possible ack is sampled at N+1.
  - If the ack is sampled at edge M, wb_valid is high from M to M+1, and mem_stall is high from N to M.
  - The next instruction, held by upstream, is accepted at edge M+1. This one-cycle bubble is required behaviour.
- Back-to-back non-memory instructions give a continuous wb_valid.
- Memory latency is unbounded; there is no timeout.

## Structure
- Shared CPU package holds:
  - opcode constants OP_LW = 4'b1000 and OP_SW = 4'b1001, shared with the ALU and decode;
  - the state typedef {IDLE, ACCESS}.
- One sub-module: mem_access_fsm. It owns the state register, dmem_req, mem_stall and stall_count.
- The top level holds the datapath registers.

## Test plan
- ADD result 16'h1234, rd = 3, reg_write = 1 at edge 1 -> wb_valid pulse after edge 1, wb_data = 16'h1234, wb_rd = 3, dmem_req never asserted.
- LW with alu_result 16'h0041, ack after 3 req cycles with rdata = 16'hBEEF:
  - dmem_addr = 16'h0040, dmem_we = 0, mem_stall high for 3 cycles;
  - a single wb_valid with wb_data = 16'hBEEF;
  - stall_count = 3.
- SW with alu_result 16'h0010, store_data 16'h00AA, immediate ack -> dmem_we = 1, dmem_wdata = 16'h00AA, wb_valid with wb_reg_write = 0; a following XOR presented is captured one cycle after the ack edge.
- Flush asserted with a valid LW -> no dmem_req, no wb_valid. Flush asserted during ACCESS -> transaction completes normally.
- rst asserted mid-ACCESS, then a spurious dmem_ack after reset -> all outputs 0 immediately, state IDLE, ack ignored, next ADD processed normally.
- Forced stall_count = 16'hFFFE, then a 5-cycle memory stall -> count holds at 16'hFFFF.
